// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_mem1 between the core LSU (C) and the
// host loader (H), with a host-exclusive mode and a contention counter.
module dmem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   output logic          c_stall,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   output logic          h_ack,
   output logic [DW-1:0] h_rdata,
   input  logic          h_excl,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [CW-1:0] conflict_cnt,
   input  logic          clr_cnt
);

   typedef enum logic [1:0] {IDLE, GNT_C, GNT_H} state_t;

   localparam logic RR_C = 1'b0;
   localparam logic RR_H = 1'b1;

   state_t state;
   state_t state_nxt;
   logic   rr_last;
   logic   rr_nxt;
   logic   elig_c;
   logic   elig_h;
   logic   cand_c;
   logic   cand_h;
   logic   contend;
   logic   cnt_max;

   assign elig_c  = c_req & ~h_excl;
   assign elig_h  = h_req;
   // the granted side still holds req for its in-flight access
   assign cand_c  = elig_c & (state != GNT_C);
   assign cand_h  = elig_h & (state != GNT_H);
   assign contend = elig_c & elig_h & (state == IDLE);
   assign cnt_max = (conflict_cnt == {CW{1'b1}});

   assign c_stall = c_req & ~c_ack;

   always_comb begin
      state_nxt = IDLE;
      rr_nxt    = rr_last;
      priority case (1'b1)
         cand_c & cand_h:
            state_nxt = (rr_last == RR_H) ? GNT_C : GNT_H;
         cand_c:
            state_nxt = GNT_C;
         cand_h:
            state_nxt = GNT_H;
         default:
            state_nxt = IDLE;
      endcase
      if (state_nxt == GNT_C) rr_nxt = RR_C;
      if (state_nxt == GNT_H) rr_nxt = RR_H;
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      unique case (state)
         GNT_C: begin
            mem_addr  = c_addr;
            mem_we    = c_we;
            mem_wdata = c_wdata;
         end
         GNT_H: begin
            mem_addr  = h_addr;
            mem_we    = h_we;
            mem_wdata = h_wdata;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_last <= RR_H;
         c_ack   <= 1'b0;
         h_ack   <= 1'b0;
         c_rdata <= '0;
         h_rdata <= '0;
      end else begin
         state   <= state_nxt;
         rr_last <= rr_nxt;
         c_ack   <= (state == GNT_C);
         h_ack   <= (state == GNT_H);
         if (state == GNT_C && !c_we) c_rdata <= mem_rdata;
         if (state == GNT_H && !h_we) h_rdata <= mem_rdata;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (clr_cnt) begin
         conflict_cnt <= '0;
      end else if (contend && !cnt_max) begin
         conflict_cnt <= conflict_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, access table and scoreboard
// queues, plus hand sequences for tie, alternation, exclusive and reset.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       c_req, c_we, c_ack, c_stall;
   logic [7:0] c_addr, c_wdata, c_rdata;
   logic       h_req, h_we, h_ack, h_excl;
   logic [7:0] h_addr, h_wdata, h_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_we;
   logic [15:0] conflict_cnt;
   logic       clr_cnt;

   logic       s_c_req, s_c_ack, s_c_stall;
   logic [7:0] s_c_rdata;
   logic       s_h_req, s_h_ack;
   logic [7:0] s_h_rdata;
   logic [7:0] s_mem_addr, s_mem_wdata;
   logic       s_mem_we;
   logic [7:0] s_mem_rdata;
   logic [2:0] s_cnt;
   logic       s_clr;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .CLK(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_ack(h_ack), .h_rdata(h_rdata), .h_excl(h_excl),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt),
      .clr_cnt(clr_cnt)
   );

   dmem_arbiter #(.CW(3)) sat (
      .CLK(clk), .rst_n(rst_n),
      .c_req(s_c_req), .c_we(1'b0), .c_addr(8'h00), .c_wdata(8'h00),
      .c_ack(s_c_ack), .c_rdata(s_c_rdata), .c_stall(s_c_stall),
      .h_req(s_h_req), .h_we(1'b0), .h_addr(8'h00), .h_wdata(8'h00),
      .h_ack(s_h_ack), .h_rdata(s_h_rdata), .h_excl(1'b0),
      .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata),
      .mem_rdata(s_mem_rdata), .conflict_cnt(s_cnt),
      .clr_cnt(s_clr)
   );

   assign s_mem_rdata = 8'h00;

   // data_mem1 model: combinational read, synchronous write
   logic [7:0] mem [256];
   logic       mem_init;
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   typedef struct {
      bit         is_h;
      bit         we;
      bit         excl;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] sb_q[$];
   logic [7:0] cq[$];
   logic [7:0] hq[$];
   vec_t       vt[10];
   vec_t       c_ops[3];
   vec_t       h_ops[3];
   logic [7:0] exp_addr[6];
   logic       exp_we[6];
   int         ci, hi, c_last, h_last, nbad, lat;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_c(input vec_t v);
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
      cq.push_back(v.exp_rdata);
   endtask

   task automatic drive_h(input vec_t v);
      h_req = 1'b1; h_we = v.we; h_addr = v.addr; h_wdata = v.wdata;
      hq.push_back(v.exp_rdata);
   endtask

   task automatic run_row(input vec_t v, input string nm);
      int         rlat, nwe, nstall;
      logic [7:0] got;
      rlat = 0;
      h_excl = v.excl;
      if (v.is_h) begin
         h_req = 1'b1; h_we = v.we; h_addr = v.addr; h_wdata = v.wdata;
      end else begin
         c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
      end
      sb_q.push_back(v.exp_rdata);
      #1;
      nstall = int'(c_stall);
      nwe = int'(mem_we);
      for (int k = 1; k <= 8 && rlat == 0; k++) begin
         tick();
         if (v.is_h ? h_ack : c_ack) begin
            rlat = k;
            got = v.is_h ? h_rdata : c_rdata;
            h_req = 1'b0; c_req = 1'b0; h_excl = 1'b0;
            check({nm, "_rdata"}, got, sb_q.pop_front());
         end
         #1;
         nstall += int'(c_stall);
         nwe += int'(mem_we);
      end
      if (rlat == 0) begin
         sb_q.delete();
         h_req = 1'b0; c_req = 1'b0; h_excl = 1'b0;
      end
      check({nm, "_latency"}, rlat, 2);
      check({nm, "_stall_cycles"}, nstall, v.is_h ? 0 : 2);
      check({nm, "_we_cycles"}, nwe, int'(v.we));
      tick();
      check({nm, "_no_extra_ack"}, {c_ack, h_ack}, 2'b00);
   endtask

   task automatic sat_conflict(input bit clr);
      bit cd, hd;
      cd = 1'b0; hd = 1'b0;
      s_c_req = 1'b1; s_h_req = 1'b1; s_clr = clr;
      for (int k = 0; k < 8 && !(cd && hd); k++) begin
         tick();
         s_clr = 1'b0;
         if (s_c_ack) begin s_c_req = 1'b0; cd = 1'b1; end
         if (s_h_ack) begin s_h_req = 1'b0; hd = 1'b1; end
      end
      s_c_req = 1'b0; s_h_req = 1'b0;
      check("sat_both_acked", {cd, hd}, 2'b11);
      tick();
   endtask

   initial begin
      vt[0] = '{1, 1, 1, 8'h01, 8'h04, 8'h00};
      vt[1] = '{0, 0, 0, 8'h01, 8'h00, 8'h04};
      vt[2] = '{1, 1, 0, 8'h20, 8'h5A, 8'h00};
      vt[3] = '{0, 1, 0, 8'hFF, 8'hC3, 8'h04};
      vt[4] = '{1, 0, 0, 8'hFF, 8'h00, 8'hC3};
      vt[5] = '{0, 0, 0, 8'h20, 8'h00, 8'h5A};
      vt[6] = '{1, 0, 0, 8'h00, 8'h00, 8'hFF};
      vt[7] = '{0, 0, 0, 8'h80, 8'h00, 8'h7F};
      vt[8] = '{1, 1, 0, 8'h00, 8'h11, 8'hFF};
      vt[9] = '{1, 0, 0, 8'h00, 8'h00, 8'h11};
      c_ops[0] = '{0, 0, 0, 8'h01, 8'h00, 8'h04};
      c_ops[1] = '{0, 1, 0, 8'h40, 8'h99, 8'h04};
      c_ops[2] = '{0, 0, 0, 8'h80, 8'h00, 8'h7F};
      h_ops[0] = '{1, 0, 0, 8'h20, 8'h00, 8'h5A};
      h_ops[1] = '{1, 0, 0, 8'h40, 8'h00, 8'h99};
      h_ops[2] = '{1, 0, 0, 8'hFF, 8'h00, 8'hC3};
      exp_addr = '{8'h01, 8'h20, 8'h40, 8'h40, 8'h80, 8'hFF};
      exp_we   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; mem_init = 1'b1; clr_cnt = 1'b0; h_excl = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      s_c_req = 1'b0; s_h_req = 1'b0; s_clr = 1'b0;
      tick();
      tick();
      mem_init = 1'b0;
      check("rst_acks", {c_ack, h_ack}, 2'b00);
      check("rst_c_rdata", c_rdata, 8'h00);
      check("rst_h_rdata", h_rdata, 8'h00);
      check("rst_cnt", conflict_cnt, 16'h0000);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 8'h00);
      check("rst_mem_wdata", mem_wdata, 8'h00);
      rst_n = 1'b1;
      tick();

      for (int r = 0; r < 10; r++) run_row(vt[r], $sformatf("row%0d", r));
      check("mem_1", mem[1], 8'h04);
      check("mem_20", mem[8'h20], 8'h5A);
      check("mem_ff", mem[8'hFF], 8'hC3);

      // simultaneous requests straight after reset: core wins the tie
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      c_last = 0; h_last = 0;
      drive_c(c_ops[0]);
      drive_h(h_ops[0]);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) check("tie_c_first", mem_addr, 8'h01);
         if (k == 2) check("tie_h_next", mem_addr, 8'h20);
         if (c_ack) begin
            c_last = k; c_req = 1'b0;
            if (cq.size() != 0) check("tie_c_rdata", c_rdata, cq.pop_front());
            else check("tie_c_spurious_ack", c_ack, 1'b0);
         end
         if (h_ack) begin
            h_last = k; h_req = 1'b0;
            if (hq.size() != 0) check("tie_h_rdata", h_rdata, hq.pop_front());
            else check("tie_h_spurious_ack", h_ack, 1'b0);
         end
      end
      check("tie_c_ack_cycle", c_last, 2);
      check("tie_h_ack_cycle", h_last, 3);
      check("tie_cnt", conflict_cnt, 16'h0001);

      // both held: strict alternation, one access per cycle
      ci = 0; hi = 0; c_last = 0; h_last = 0;
      drive_c(c_ops[0]);
      drive_h(h_ops[0]);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k <= 6) begin
            check($sformatf("alt_addr%0d", k), mem_addr, exp_addr[k-1]);
            check($sformatf("alt_we%0d", k), mem_we, exp_we[k-1]);
         end
         if (c_ack) begin
            c_last = k;
            if (cq.size() != 0) check("alt_c_rdata", c_rdata, cq.pop_front());
            else check("alt_c_spurious_ack", c_ack, 1'b0);
            ci++;
            if (ci < 3) drive_c(c_ops[ci]);
            else c_req = 1'b0;
         end
         if (h_ack) begin
            h_last = k;
            if (hq.size() != 0) check("alt_h_rdata", h_rdata, hq.pop_front());
            else check("alt_h_spurious_ack", h_ack, 1'b0);
            hi++;
            if (hi < 3) drive_h(h_ops[hi]);
            else h_req = 1'b0;
         end
      end
      c_req = 1'b0; h_req = 1'b0;
      check("alt_c_count", ci, 3);
      check("alt_h_count", hi, 3);
      check("alt_c_last", c_last, 6);
      check("alt_h_last", h_last, 7);
      check("alt_cnt", conflict_cnt, 16'h0002);

      // exclusive mode holds the core off indefinitely
      h_excl = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20;
      nbad = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (c_ack || !c_stall) nbad++;
      end
      check("excl_blocked", nbad, 0);
      h_excl = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         tick();
         if (c_ack) begin
            lat = k;
            c_req = 1'b0;
            check("excl_rdata", c_rdata, 8'h5A);
         end
      end
      c_req = 1'b0;
      check("excl_release_latency", lat, 2);
      tick();

      // exclusive rising mid-grant: access completes, no regrant
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h01;
      tick();
      check("excl_mid_grant_addr", mem_addr, 8'h01);
      h_excl = 1'b1;
      tick();
      check("excl_mid_ack", c_ack, 1'b1);
      check("excl_mid_rdata", c_rdata, 8'h04);
      nbad = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (c_ack) nbad++;
      end
      check("excl_mid_no_regrant", nbad, 0);
      c_req = 1'b0; h_excl = 1'b0;
      tick();

      // reset during a host write grant
      h_req = 1'b1; h_we = 1'b1; h_addr = 8'h0C; h_wdata = 8'hFF;
      tick();
      check("rstmid_we_before", mem_we, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rstmid_mem_we", mem_we, 1'b0);
      check("rstmid_mem_addr", mem_addr, 8'h00);
      check("rstmid_mem_wdata", mem_wdata, 8'h00);
      check("rstmid_rdata", {c_rdata, h_rdata}, 16'h0000);
      check("rstmid_cnt", conflict_cnt, 16'h0000);
      h_req = 1'b0; h_we = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("rstmid_mem12", mem[12], 8'hF3);
      check("rstmid_no_ack", {c_ack, h_ack}, 2'b00);
      check("rstmid_idle", mem_addr, 8'h00);

      // saturation on a narrow counter, then clear beats increment
      for (int i = 0; i < 9; i++) begin
         sat_conflict(1'b0);
         check($sformatf("sat_cnt%0d", i), s_cnt, (i < 7) ? i + 1 : 7);
      end
      sat_conflict(1'b1);
      check("sat_clr_priority", s_cnt, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 256x8 data memory (data_mem1) between two requesters: the CPU core's load/store unit (port C) and a host/debug loader (port H).
- Port H preloads inputs before `start` and reads results after `halt`.
- Round-robin arbitration, an exclusive mode that blocks the core during preload, and a saturating conflict counter for performance checks.
- Sits between TopLevel's datapath and data_mem1. The memory read is combinational and the write is synchronous.

Parameters:
- AW, 8, data memory address width (256 entries)
- DW, 8, data width
- CW, 16, conflict counter width

Ports:
- CLK  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  core access request; held until c_ack
- c_we  in  1  core write enable (1 = store)
- c_addr  in  AW  core address
- c_wdata  in  DW  core store data
- c_ack  out  1  one-cycle pulse: core access complete
- c_rdata  out  DW  core load data, valid with c_ack
- c_stall  out  1  core must freeze PC: c_req high and no c_ack this cycle
- h_req  in  1  host access request; held until h_ack
- h_we  in  1  host write enable
- h_addr  in  AW  host address
- h_wdata  in  DW  host write data
- h_ack  out  1  one-cycle pulse: host access complete
- h_rdata  out  DW  host read data, valid with h_ack
- h_excl  in  1  host exclusive mode: core requests never granted
- mem_addr  out  AW  to data_mem1
- mem_we  out  1  to data_mem1
- mem_wdata  out  DW  to data_mem1
- mem_rdata  in  DW  from data_mem1, combinational read
- conflict_cnt  out  CW  saturating count of contended arbitrations
- clr_cnt  in  1  synchronous clear of conflict_cnt

Behaviour:
- Reset values:
  - state=IDLE, rr_last=H (so the core wins the first tie).
  - c_ack=h_ack=0, c_rdata=h_rdata=0, conflict_cnt=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, GNT_C, GNT_H. State, rr_last, acks, rdata and conflict_cnt are registers.
- Eligibility:
  - elig_C = c_req & ~h_excl.
  - elig_H = h_req.
  - In GNT_x, requester x is masked from arbitration, because its req is still high for the current access.
- Arbitration (evaluated every cycle, on the unmasked eligible set):
  - If only one requester is eligible, it wins.
  - If both are eligible, the one not equal to rr_last wins.
  - If none are eligible, next state is IDLE.
- Transitions:
  - IDLE goes to GNT_<winner>, or stays in IDLE.
  - GNT_x goes to GNT_<other> if the other is eligible, else to IDLE.
  - rr_last is updated to x on entering GNT_x.
- In GNT_x:
  - mem_addr/mem_we/mem_wdata = x's addr/we/wdata, combinational from state.
  - The write commits at the clock edge ending GNT_x.
  - x_rdata is loaded from mem_rdata at that same edge, for reads only; it holds its prior value on writes.
  - x_ack is registered and high exactly the cycle after GNT_x.
- Outside GNT states: mem_we=0, mem_addr/mem_wdata=0.
- Latency:
  - From IDLE: req seen in cycle N, grant in N+1, ack + rdata in N+2.
  - A requester keeping req high in its ack cycle starts a new request.
  - Lone requester throughput: 1 access per 2 cycles. Alternating requesters: 1 access per cycle.
- c_stall = c_req & ~c_ack (combinational).
- Conflict counter:
  - Increments when both c_req & ~h_excl and h_req are high while the arbiter is making a grant decision from IDLE.
  - Saturates at 2^CW-1.
  - clr_cnt has priority over increment.
- h_excl:
  - Rising mid-GNT_C: the current core access completes normally; the core is not regranted while h_excl=1.
  - Falling: the core becomes eligible in the same cycle.
- Requester dropping req before ack: illegal; the access still completes and acks.
- Reset mid-access: outputs return to reset values immediately; no write commits after rst_n falls.
- Write then read of the same address by different requesters in consecutive grants: the read returns the new data, because the write commits before the next grant cycle.

Test Plan:
- Reset, then host writes 0x04 to addr 1 with h_excl=1: mem_we high for exactly one cycle; h_ack 2 cycles after h_req; core[1]=0x04.
- Core reads addr 1 alone: c_ack and c_rdata=0x04 2 cycles after c_req; c_stall high for exactly 2 cycles.
- c_req and h_req asserted together from IDLE after reset: core granted first, host next cycle; acks in consecutive cycles; conflict_cnt=1.
- Both held continuously for 6 accesses: grants alternate C,H,C,H,C,H; no idle cycles.
- h_excl=1 with c_req held for 10 cycles: no c_ack and c_stall=1 throughout. h_excl falls: c_ack 2 cycles later.
- rst_n pulsed low during GNT_H write of 0xFF to addr 12: core[12] unchanged; all outputs 0; state IDLE. Force conflict_cnt to 0xFFFE and apply 3 conflicts: it holds at 0xFFFF.
